// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle used three times around the arbiter: once for the
// fetch requester, once for the data requester and once for the shared
// memory port toward the bus bridge. The requesting side drives the request
// fields; the responding side drives the handshakes and the read data.
interface mem_port_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one sram-like memory port between the instruction-fetch and the
// data-access requesters. One transaction at a time: grant (IDLE decision),
// address handshake (ADDR), data return (DATA). Data has fixed priority over
// fetch, but only for MAX_DATA_STREAK consecutive grants while a fetch is
// waiting; after that the fetch is granted so it always makes progress.
module mem_port_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  inst_port,
    mem_port_arbiter_if.slave  data_port,
    mem_port_arbiter_if.master mem_port
);

    localparam logic [3:0] STREAK_MAX_C = 4'(MAX_DATA_STREAK);
    localparam logic       OWNER_INST_C = 1'b0;
    localparam logic       OWNER_DATA_C = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_next_s;
    logic       owner_r;
    logic       owner_next_s;
    logic [3:0] streak_r;
    logic [3:0] streak_next_s;
    logic       grant_data_s;
    logic       grant_inst_s;

    // Saturating increment of the data-grant streak.
    function automatic logic [3:0] streak_inc(input logic [3:0] cur, input logic [3:0] lim);
        logic [3:0] res;
        if (cur >= lim) begin
            res = lim;
        end else begin
            res = cur + 4'd1;
        end
        return res;
    endfunction

    // Priority decision: data wins unless a fetch is waiting and data already
    // used up its streak allowance. Only consumed while in IDLE.
    always_comb begin
        grant_data_s = 1'b0;
        grant_inst_s = 1'b0;
        if (data_port.req && (!inst_port.req || (streak_r < STREAK_MAX_C))) begin
            grant_data_s = 1'b1;
        end else if (inst_port.req) begin
            grant_inst_s = 1'b1;
        end else begin
            grant_data_s = 1'b0;
            grant_inst_s = 1'b0;
        end
    end

    // Next-state, owner and streak computation for the three-phase sequence.
    always_comb begin
        state_next_s  = state_r;
        owner_next_s  = owner_r;
        streak_next_s = streak_r;
        case (state_r)
            IDLE: begin
                if (grant_data_s) begin
                    state_next_s = ADDR;
                    owner_next_s = OWNER_DATA_C;
                    if (inst_port.req) begin
                        streak_next_s = streak_inc(streak_r, STREAK_MAX_C);
                    end else begin
                        streak_next_s = 4'd0;
                    end
                end else if (grant_inst_s) begin
                    state_next_s  = ADDR;
                    owner_next_s  = OWNER_INST_C;
                    streak_next_s = 4'd0;
                end else begin
                    state_next_s  = IDLE;
                    streak_next_s = 4'd0;
                end
            end
            ADDR: begin
                // The owner must keep req up until addr_ok; if it drops it
                // anyway we keep presenting the captured owner's fields.
                if (mem_port.addr_ok) begin
                    state_next_s = DATA;
                end else begin
                    state_next_s = ADDR;
                end
            end
            DATA: begin
                if (mem_port.data_ok) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DATA;
                end
            end
            default: begin
                state_next_s  = IDLE;
                owner_next_s  = OWNER_INST_C;
                streak_next_s = 4'd0;
            end
        endcase
    end

    // State, owner and streak registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            owner_r  <= OWNER_INST_C;
            streak_r <= 4'd0;
        end else begin
            state_r  <= state_next_s;
            owner_r  <= owner_next_s;
            streak_r <= streak_next_s;
        end
    end

    // Port steering: request fields go out only in ADDR, handshakes and read
    // data reach only the owner, everything else is held at zero.
    always_comb begin
        mem_port.req       = 1'b0;
        mem_port.wr        = 1'b0;
        mem_port.size      = 2'd0;
        mem_port.wstrb     = 4'd0;
        mem_port.addr      = 32'd0;
        mem_port.wdata     = 32'd0;
        inst_port.addr_ok  = 1'b0;
        inst_port.data_ok  = 1'b0;
        inst_port.rdata    = 32'd0;
        data_port.addr_ok  = 1'b0;
        data_port.data_ok  = 1'b0;
        data_port.rdata    = 32'd0;
        case (state_r)
            IDLE: begin
                mem_port.req = 1'b0;
            end
            ADDR: begin
                mem_port.req = 1'b1;
                if (owner_r == OWNER_DATA_C) begin
                    mem_port.wr       = data_port.wr;
                    mem_port.size     = data_port.size;
                    mem_port.wstrb    = data_port.wstrb;
                    mem_port.addr     = data_port.addr;
                    mem_port.wdata    = data_port.wdata;
                    data_port.addr_ok = mem_port.addr_ok;
                end else begin
                    mem_port.wr       = inst_port.wr;
                    mem_port.size     = inst_port.size;
                    mem_port.wstrb    = inst_port.wstrb;
                    mem_port.addr     = inst_port.addr;
                    mem_port.wdata    = inst_port.wdata;
                    inst_port.addr_ok = mem_port.addr_ok;
                end
            end
            DATA: begin
                // A data_ok seen while still in ADDR never lands here, so a
                // premature slave response is not forwarded.
                if (owner_r == OWNER_DATA_C) begin
                    data_port.data_ok = mem_port.data_ok;
                    data_port.rdata   = mem_port.rdata;
                end else begin
                    inst_port.data_ok = mem_port.data_ok;
                    inst_port.rdata   = mem_port.rdata;
                end
            end
            default: begin
                mem_port.req = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a
// randomized run, all checked cycle by cycle against a transaction-level
// reference model (current transaction record plus a data-win counter).
module tb_mem_port_arbiter;

    localparam int MAX_STREAK = 4;

    typedef struct packed {
        logic        valid;
        logic        who_data;
        logic        addr_done;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic reset;

    mem_port_arbiter_if inst_bus ();
    mem_port_arbiter_if data_bus ();
    mem_port_arbiter_if mem_bus ();

    mem_port_arbiter #(.MAX_DATA_STREAK(MAX_STREAK)) dut (
        .clk       (clk),
        .reset     (reset),
        .inst_port (inst_bus),
        .data_port (data_bus),
        .mem_port  (mem_bus)
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // reference model
    txn_t cur;
    int   streak;

    // requester agents (0 = inst, 1 = data)
    logic        r_req   [2];
    logic        r_wait  [2];
    logic        r_wr    [2];
    logic [1:0]  r_size  [2];
    logic [3:0]  r_wstrb [2];
    logic [31:0] r_addr  [2];
    logic [31:0] r_wdata [2];
    int unsigned req_pct [2];

    // slave agent
    logic        slave_manual;
    logic        owe;
    int unsigned aok_pct, dok_pct, spur_pct;

    // observations
    logic        o_mreq, o_mwr;
    logic [3:0]  o_mwstrb;
    logic [31:0] o_maddr, o_mwdata;
    logic        o_aok [2];
    logic        o_dok [2];
    logic [31:0] o_rdata [2];
    int          dok_pulses [2];
    logic        grant_log [$];
    logic        exp_pat [9];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic txn_t take(input logic side);
        txn_t t;
        t.valid     = 1'b1;
        t.who_data  = side;
        t.addr_done = 1'b0;
        if (side) begin
            t.wr = data_bus.wr; t.size = data_bus.size; t.wstrb = data_bus.wstrb;
            t.addr = data_bus.addr; t.wdata = data_bus.wdata;
        end else begin
            t.wr = inst_bus.wr; t.size = inst_bus.size; t.wstrb = inst_bus.wstrb;
            t.addr = inst_bus.addr; t.wdata = inst_bus.wdata;
        end
        return t;
    endfunction

    // Apply the arbitration rules to the inputs present at this clock edge.
    task automatic model_edge();
        if (reset) begin
            cur    = '0;
            streak = 0;
        end else if (!cur.valid) begin
            if (data_bus.req && (!inst_bus.req || streak < MAX_STREAK)) begin
                cur    = take(1'b1);
                streak = inst_bus.req ? streak + 1 : 0;
            end else if (inst_bus.req) begin
                cur    = take(1'b0);
                streak = 0;
            end else begin
                streak = 0;
            end
        end else if (!cur.addr_done) begin
            if (mem_bus.addr_ok) cur.addr_done = 1'b1;
        end else begin
            if (mem_bus.data_ok) cur.valid = 1'b0;
        end
    endtask

    task automatic bench_edge();
        for (int s = 0; s < 2; s++) begin
            if (reset) begin
                r_req[s] = 1'b0; r_wait[s] = 1'b0;
            end else if (r_req[s] && o_aok[s]) begin
                r_req[s] = 1'b0; r_wait[s] = 1'b1;
            end else if (r_wait[s] && o_dok[s]) begin
                r_wait[s] = 1'b0;
            end
        end
        if (reset) owe = 1'b0;
        else if (o_mreq && mem_bus.addr_ok) owe = 1'b1;
        else if (owe && mem_bus.data_ok) owe = 1'b0;
    endtask

    task automatic drive_inputs();
        for (int s = 0; s < 2; s++) begin
            if (!reset && !r_req[s] && !r_wait[s] && $urandom_range(99) < req_pct[s]) begin
                r_req[s]   = 1'b1;
                r_wr[s]    = ($urandom_range(3) == 0);
                r_size[s]  = 2'($urandom_range(2));
                r_wstrb[s] = 4'($urandom);
                r_addr[s]  = $urandom;
                r_wdata[s] = $urandom;
            end
        end
        inst_bus.req = r_req[0]; inst_bus.wr = r_wr[0]; inst_bus.size = r_size[0];
        inst_bus.wstrb = r_wstrb[0]; inst_bus.addr = r_addr[0]; inst_bus.wdata = r_wdata[0];
        data_bus.req = r_req[1]; data_bus.wr = r_wr[1]; data_bus.size = r_size[1];
        data_bus.wstrb = r_wstrb[1]; data_bus.addr = r_addr[1]; data_bus.wdata = r_wdata[1];
        if (!slave_manual) begin
            mem_bus.addr_ok = mem_bus.req && ($urandom_range(99) < aok_pct);
            if (owe) mem_bus.data_ok = ($urandom_range(99) < dok_pct);
            else if (mem_bus.req) mem_bus.data_ok = ($urandom_range(99) < spur_pct);
            else mem_bus.data_ok = 1'b0;
            mem_bus.rdata = $urandom;
        end
    endtask

    task automatic compare_cycle();
        txn_t        shown;
        logic        e_mreq;
        logic        e_aok   [2];
        logic        e_dok   [2];
        logic [31:0] e_rdata [2];
        shown  = '0;
        e_mreq = 1'b0;
        for (int s = 0; s < 2; s++) begin
            e_aok[s] = 1'b0; e_dok[s] = 1'b0; e_rdata[s] = 32'd0;
        end
        if (cur.valid && !cur.addr_done) begin
            shown = cur;
            e_mreq = 1'b1;
            e_aok[cur.who_data] = mem_bus.addr_ok;
        end else if (cur.valid) begin
            e_dok[cur.who_data]   = mem_bus.data_ok;
            e_rdata[cur.who_data] = mem_bus.rdata;
        end
        o_mreq = mem_bus.req; o_mwr = mem_bus.wr; o_mwstrb = mem_bus.wstrb;
        o_maddr = mem_bus.addr; o_mwdata = mem_bus.wdata;
        o_aok[0] = inst_bus.addr_ok; o_dok[0] = inst_bus.data_ok; o_rdata[0] = inst_bus.rdata;
        o_aok[1] = data_bus.addr_ok; o_dok[1] = data_bus.data_ok; o_rdata[1] = data_bus.rdata;
        check_eq("mem_req",   32'(o_mreq),        32'(e_mreq));
        check_eq("mem_wr",    32'(o_mwr),         32'(shown.wr));
        check_eq("mem_size",  32'(mem_bus.size),  32'(shown.size));
        check_eq("mem_wstrb", 32'(o_mwstrb),      32'(shown.wstrb));
        check_eq("mem_addr",  o_maddr,            shown.addr);
        check_eq("mem_wdata", o_mwdata,           shown.wdata);
        check_eq("inst_addr_ok", 32'(o_aok[0]),   32'(e_aok[0]));
        check_eq("inst_data_ok", 32'(o_dok[0]),   32'(e_dok[0]));
        check_eq("inst_rdata",   o_rdata[0],      e_rdata[0]);
        check_eq("data_addr_ok", 32'(o_aok[1]),   32'(e_aok[1]));
        check_eq("data_data_ok", 32'(o_dok[1]),   32'(e_dok[1]));
        check_eq("data_rdata",   o_rdata[1],      e_rdata[1]);
        if (o_aok[0]) grant_log.push_back(1'b0);
        if (o_aok[1]) grant_log.push_back(1'b1);
        if (o_dok[0]) dok_pulses[0]++;
        if (o_dok[1]) dok_pulses[1]++;
    endtask

    // One clock cycle: drive, check mid-cycle, then advance model and agents.
    task automatic tick();
        drive_inputs();
        #1;
        compare_cycle();
        @(posedge clk);
        model_edge();
        bench_edge();
        #1;
    endtask

    task automatic run_until_grants(input int n, input int budget, input string tag);
        for (int c = 0; c < budget && grant_log.size() < n; c++) tick();
        check_eq(tag, 32'(grant_log.size() >= n), 32'd1);
    endtask

    task automatic set_req(input int s, input logic wr, input logic [3:0] wstrb,
                           input logic [31:0] addr, input logic [31:0] wdata);
        r_req[s] = 1'b1; r_wr[s] = wr; r_size[s] = 2'd2;
        r_wstrb[s] = wstrb; r_addr[s] = addr; r_wdata[s] = wdata;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        cur = '0; streak = 0; owe = 1'b0;
        for (int s = 0; s < 2; s++) begin
            r_req[s] = 1'b0; r_wait[s] = 1'b0; r_wr[s] = 1'b0; r_size[s] = 2'd0;
            r_wstrb[s] = 4'd0; r_addr[s] = 32'd0; r_wdata[s] = 32'd0;
            req_pct[s] = 0; dok_pulses[s] = 0;
        end
        slave_manual = 1'b1; aok_pct = 0; dok_pct = 0; spur_pct = 0;
        mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b0; mem_bus.rdata = 32'd0;
        reset = 1'b1;
        drive_inputs();
        @(posedge clk); #1;
        tick(); tick();
        reset = 1'b0;
        tick();
        check_eq("reset_mem_req", 32'(o_mreq), 32'd0);
        check_eq("reset_mem_addr", o_maddr, 32'd0);

        // single read with fastest slave
        set_req(1, 1'b0, 4'hF, 32'h1C000010, 32'd0);
        tick();
        check_eq("rd_c1_addr_ok", 32'(o_aok[1]), 32'd0);
        mem_bus.addr_ok = 1'b1;
        tick();
        check_eq("rd_c2_addr_ok", 32'(o_aok[1]), 32'd1);
        check_eq("rd_c2_addr", o_maddr, 32'h1C000010);
        mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'hDEADBEEF;
        tick();
        check_eq("rd_c3_data_ok", 32'(o_dok[1]), 32'd1);
        check_eq("rd_c3_rdata", o_rdata[1], 32'hDEADBEEF);
        check_eq("rd_inst_quiet", 32'({o_aok[0], o_dok[0]}), 32'd0);
        check_eq("rd_inst_rdata", o_rdata[0], 32'd0);
        mem_bus.data_ok = 1'b0; mem_bus.rdata = 32'd0;
        tick();

        // write with a 5-cycle address stall and a premature data_ok
        dok_pulses[1] = 0;
        set_req(1, 1'b1, 4'b0011, 32'h1C000020, 32'h0000ABCD);
        tick();
        for (int i = 0; i < 5; i++) begin
            mem_bus.data_ok = (i == 2);
            tick();
            check_eq("st_mem_req", 32'(o_mreq), 32'd1);
            check_eq("st_mem_addr", o_maddr, 32'h1C000020);
            check_eq("st_no_fwd", 32'(o_dok[1]), 32'd0);
            check_eq("wr_mem_wr", 32'(o_mwr), 32'd1);
            check_eq("wr_mem_wstrb", 32'(o_mwstrb), 32'h3);
            check_eq("wr_mem_wdata", o_mwdata, 32'h0000ABCD);
        end
        mem_bus.data_ok = 1'b0; mem_bus.addr_ok = 1'b1;
        tick();
        check_eq("wr_addr_ok", 32'(o_aok[1]), 32'd1);
        mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1;
        tick();
        mem_bus.data_ok = 1'b0;
        tick();
        check_eq("wr_done_pulses", 32'(dok_pulses[1]), 32'd1);

        // collision: data first, inst only after data done plus one IDLE cycle
        set_req(0, 1'b0, 4'hF, 32'h1C000000, 32'd0);
        set_req(1, 1'b0, 4'hF, 32'h1C000040, 32'd0);
        tick();
        mem_bus.addr_ok = 1'b1;
        tick();
        check_eq("col_data_first", 32'(o_aok[1]), 32'd1);
        check_eq("col_inst_wait", 32'(o_aok[0]), 32'd0);
        mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h12345678;
        tick();
        check_eq("col_data_done", 32'(o_dok[1]), 32'd1);
        mem_bus.data_ok = 1'b0;
        tick();
        check_eq("col_idle_gap", 32'(o_mreq), 32'd0);
        tick();
        check_eq("col_inst_addr", o_maddr, 32'h1C000000);
        mem_bus.addr_ok = 1'b1;
        tick();
        mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1;
        tick();
        mem_bus.data_ok = 1'b0;
        tick();

        // starvation: both always requesting
        slave_manual = 1'b0; aok_pct = 100; dok_pct = 100; spur_pct = 0;
        req_pct[0] = 100; req_pct[1] = 100;
        grant_log.delete();
        exp_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        run_until_grants(9, 200, "starve_progress");
        for (int i = 0; i < 9; i++) begin
            if (grant_log.size() > i) check_eq("starve_order", 32'(grant_log[i]), 32'(exp_pat[i]));
        end

        // reset while the ninth (data) transaction waits for data_ok
        dok_pct = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0; dok_pct = 100;
        grant_log.delete();
        tick();
        check_eq("rst_mem_req", 32'(o_mreq), 32'd0);
        check_eq("rst_oks", 32'({o_aok[0], o_aok[1], o_dok[0], o_dok[1]}), 32'd0);
        run_until_grants(1, 20, "rst_regrant");
        if (grant_log.size() > 0) check_eq("rst_streak_cleared", 32'(grant_log[0]), 32'd1);
        req_pct[0] = 0; req_pct[1] = 0;
        run_until_grants(2, 20, "rst_inst_progress");
        if (grant_log.size() > 1) check_eq("rst_inst_grant", 32'(grant_log[1]), 32'd0);
        for (int i = 0; i < 6; i++) tick();

        // randomized traffic with occasional resets
        aok_pct = 60; dok_pct = 60; spur_pct = 20;
        for (int ep = 0; ep < 15; ep++) begin
            req_pct[0] = $urandom_range(100);
            req_pct[1] = $urandom_range(100);
            for (int c = 0; c < 200; c++) begin
                reset = ($urandom_range(99) == 0);
                tick();
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
